// File: rtl/uart_line_buffer.sv
// uart_line_buffer: assembles received bytes into a line and replays it through the UART
// transmit handshake on CR, followed by an optional '!' overflow marker and CR LF.
module uart_line_buffer #(
  parameter int DEPTH = 16,
  parameter int GUARD = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_valid_i,
  input  logic [7:0] rx_data_i,
  input  logic       rx_error_i,
  input  logic       tx_busy_i,
  output logic       tx_start_o,
  output logic [7:0] tx_data_o,
  output logic       busy_o,
  output logic       overflow_o,
  output logic [7:0] drop_count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = $clog2(GUARD + 1);
  typedef enum logic [2:0] {
    COLLECT, LOAD, ISSUE, GUARD_WAIT, IDLE_WAIT, SUFFIX_BANG, SUFFIX_CR, SUFFIX_LF
  } state_t;
  // Which byte the shared ISSUE/GUARD_WAIT/IDLE_WAIT path returns from
  typedef enum logic [1:0] {PH_DATA, PH_BANG, PH_CR, PH_LF} phase_t;
  state_t state_q, state_d;
  phase_t phase_q, phase_d;
  logic [CW-1:0] count_q, count_d, rd_ptr_q, rd_ptr_d;
  logic [GW-1:0] g_q, g_d;
  logic [7:0] tx_data_q, tx_data_d, drop_q, drop_d;
  logic overflow_q, overflow_d, we;
  logic [7:0] mem_q [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem_q[count_q[AW-1:0]] <= rx_data_i;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= COLLECT;
      phase_q    <= PH_DATA;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      g_q        <= '0;
      tx_data_q  <= '0;
      drop_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      g_q        <= g_d;
      tx_data_q  <= tx_data_d;
      drop_q     <= drop_d;
      overflow_q <= overflow_d;
    end
  end
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    g_d        = g_q;
    tx_data_d  = tx_data_q;
    drop_d     = drop_q;
    overflow_d = overflow_q;
    we         = 1'b0;
    tx_start_o = 1'b0;
    if (state_q != COLLECT && rx_valid_i && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    case (state_q)
      COLLECT: begin
        if (rx_error_i) begin
          count_d    = '0;
          overflow_d = 1'b0;
        end else if (rx_valid_i) begin
          if (rx_data_i == 8'h0D) begin
            state_d  = LOAD;
            rd_ptr_d = '0;
            phase_d  = PH_DATA;
          end else if (rx_data_i == 8'h08) begin
            if (count_q != '0) count_d = count_q - CW'(1);
          end else if (rx_data_i != 8'h0A) begin
            if (count_q < CW'(DEPTH)) begin
              we      = 1'b1;
              count_d = count_q + CW'(1);
            end else overflow_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (rd_ptr_q < count_q) begin
          tx_data_d = mem_q[rd_ptr_q[AW-1:0]];
          state_d   = ISSUE;
        end else state_d = overflow_q ? SUFFIX_BANG : SUFFIX_CR;
      end
      SUFFIX_BANG: begin
        tx_data_d = 8'h21;
        phase_d   = PH_BANG;
        state_d   = ISSUE;
      end
      SUFFIX_CR: begin
        tx_data_d = 8'h0D;
        phase_d   = PH_CR;
        state_d   = ISSUE;
      end
      SUFFIX_LF: begin
        tx_data_d = 8'h0A;
        phase_d   = PH_LF;
        state_d   = ISSUE;
      end
      ISSUE: begin
        if (!tx_busy_i) begin
          tx_start_o = 1'b1;
          g_d        = '0;
          state_d    = GUARD_WAIT;
        end
      end
      GUARD_WAIT: begin
        if (g_q == GW'(GUARD - 1)) state_d = IDLE_WAIT;
        else g_d = g_q + GW'(1);
      end
      IDLE_WAIT: begin
        if (!tx_busy_i) begin
          state_d = phase_q == PH_DATA ? LOAD : phase_q == PH_BANG ? SUFFIX_CR :
                    phase_q == PH_CR ? SUFFIX_LF : COLLECT;
          if (phase_q == PH_DATA) rd_ptr_d = rd_ptr_q + CW'(1);
          if (phase_q == PH_LF) begin
            count_d    = '0;
            overflow_d = 1'b0;
          end
        end
      end
      default: state_d = COLLECT;
    endcase
  end
  assign tx_data_o    = tx_data_q;
  assign busy_o       = state_q != COLLECT;
  assign overflow_o   = overflow_q;
  assign drop_count_o = drop_q;
endmodule

// File: tb/tb_uart_line_buffer.sv
// tb_uart_line_buffer: directed checks of line assembly and replay against a UART transmitter stub.
module tb_uart_line_buffer;
  logic clk = 1'b0, rst_n = 1'b0, rx_valid = 1'b0, rx_error = 1'b0, hold_busy = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic tx_start, busy, overflow, tx_busy;
  logic [7:0] tx_data, drop_count;
  int npass = 0, ntot = 0, viol = 0, bcnt = 0, starts;
  logic [7:0] rxq [$];
  always #5 clk = ~clk;
  assign tx_busy = hold_busy || bcnt != 0;
  uart_line_buffer #(.DEPTH(4), .GUARD(2)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid_i(rx_valid), .rx_data_i(rx_data),
    .rx_error_i(rx_error), .tx_busy_i(tx_busy), .tx_start_o(tx_start),
    .tx_data_o(tx_data), .busy_o(busy), .overflow_o(overflow), .drop_count_o(drop_count)
  );
  always @(posedge clk) begin
    if (tx_start) begin
      if (tx_busy) viol <= viol + 1;
      rxq.push_back(tx_data);
      bcnt <= 6;
    end else if (bcnt != 0) bcnt <= bcnt - 1;
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ntot++;
    assert (got === exp) npass++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  function automatic logic [63:0] packq();
    logic [63:0] v = '0;
    foreach (rxq[i]) v = {v[55:0], rxq[i]};
    return v;
  endfunction
  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask
  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask
  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {63'd0, busy}, 64'd0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("reset_outputs", {32'd0, 7'd0, tx_start, tx_data, 7'd0, busy, 7'd0, overflow, drop_count}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    rxq.delete();
    send_str("abc");
    rx_data = 8'h0D;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    chk("load_busy", {63'd0, busy}, 64'd1);
    chk("load_no_start", {63'd0, tx_start}, 64'd0);
    @(negedge clk);
    chk("first_start", {63'd0, tx_start}, 64'd1);
    chk("first_data", {56'd0, tx_data}, 64'h61);
    wait_idle("idle_abc");
    chk("line_abc", packq(), 64'h616263_0D0A);
    rxq.delete();
    send(8'h0D);
    wait_idle("idle_empty");
    chk("line_empty", packq(), 64'h0D0A);
    rxq.delete();
    send_str("abcdef");
    chk("ovf_set", {63'd0, overflow}, 64'd1);
    send(8'h0D);
    chk("ovf_during", {63'd0, overflow}, 64'd1);
    wait_idle("idle_ovf");
    chk("line_ovf", packq(), 64'h61626364_210D0A);
    chk("ovf_cleared", {63'd0, overflow}, 64'd0);
    rxq.delete();
    send_str("ab");
    send(8'h08);
    send_str("c");
    send(8'h0A);
    send(8'h0D);
    wait_idle("idle_bs");
    chk("line_bs", packq(), 64'h6163_0D0A);
    rxq.delete();
    send(8'h08);
    send(8'h0D);
    wait_idle("idle_bs_empty");
    chk("line_bs_empty", packq(), 64'h0D0A);
    rxq.delete();
    send_str("q");
    send(8'h0D);
    send_str("rst");
    wait_idle("idle_drop");
    chk("drop_3", {56'd0, drop_count}, 64'd3);
    chk("line_drop", packq(), 64'h71_0D0A);
    hold_busy = 1'b1;
    rxq.delete();
    send(8'h0D);
    repeat (258) send(8'h55);
    chk("drop_sat", {56'd0, drop_count}, 64'd255);
    hold_busy = 1'b0;
    wait_idle("idle_sat");
    chk("line_sat", packq(), 64'h0D0A);
    rxq.delete();
    send_str("xy");
    rx_error = 1'b1;
    @(negedge clk);
    rx_error = 1'b0;
    send_str("z");
    send(8'h0D);
    wait_idle("idle_err");
    chk("line_err", packq(), 64'h7A_0D0A);
    rxq.delete();
    rx_data = 8'h0D;
    rx_valid = 1'b1;
    rx_error = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_error = 1'b0;
    chk("err_cr_busy", {63'd0, busy}, 64'd0);
    repeat (20) @(negedge clk);
    chk("err_cr_silent", 64'(rxq.size()), 64'd0);
    hold_busy = 1'b1;
    rxq.delete();
    send_str("k");
    send(8'h0D);
    starts = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx_start) starts++;
    end
    chk("hold_no_start", 64'(starts), 64'd0);
    chk("hold_busy", {63'd0, busy}, 64'd1);
    hold_busy = 1'b0;
    wait_idle("idle_hold");
    chk("line_hold", packq(), 64'h6B_0D0A);
    rxq.delete();
    send_str("mn");
    send(8'h0D);
    repeat (4) @(negedge clk);
    chk("mid_busy", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_reset", {32'd0, 7'd0, tx_start, tx_data, 7'd0, busy, 7'd0, overflow, drop_count}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    rxq.delete();
    send_str("ok");
    send(8'h0D);
    wait_idle("idle_after_rst");
    chk("line_after_rst", packq(), 64'h6F6B_0D0A);
    chk("no_start_while_busy", 64'(viol), 64'd0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
